// File: rtl/face_result_streamer.sv
// face_result_streamer
//   Circular FIFO of face-detection records plus a byte serialiser feeding the
//   UART transmitter. Records queued when a frame ends are streamed byte 0
//   first, one byte per tx_send/tx_done handshake, each byte gated by CTS.
//   A frame with no records produces a single NONE_BYTE.
// Ports
//   clock, reset      system clock, asynchronous active-high reset
//   rec_valid/data    1-cycle record push
//   frame_done        1-cycle end-of-frame strobe
//   cts               laptop ready to receive
//   tx_done           transmitter finished the current byte
//   tx_send/tx_byte   byte request to the transmitter, held until tx_done
//   count             records stored
//   busy              serialiser active
//   overflow          sticky dropped-push flag
//   drop_count        saturating dropped-push counter
//
// state    | meaning
// IDLE     | waiting for a frame end (live strobe or pending)
// LOAD     | pop head record into the shift register
// WAIT_CTS | next byte ready, waiting for cts
// XMIT     | byte on tx_byte, tx_send high until tx_done
// NONE     | empty frame: send NONE_BYTE once cts seen
module face_result_streamer #(
  parameter int         DEPTH     = 100,
  parameter int         REC_BYTES = 16,
  parameter logic [7:0] NONE_BYTE = 8'h00,
  localparam int        CW        = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rec_valid,
  input  logic [REC_BYTES*8-1:0] rec_data,
  input  logic                   frame_done,
  input  logic                   cts,
  input  logic                   tx_done,
  output logic                   tx_send,
  output logic [7:0]             tx_byte,
  output logic [CW-1:0]          count,
  output logic                   busy,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
  localparam int RW = REC_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_CTS,
    S_XMIT,
    S_NONE
  } state_t;

  state_t state, next_state;

  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [RW-1:0] shreg;
  logic [BW-1:0] byte_idx;
  logic [CW-1:0] burst_left;
  logic          pending;
  logic          none_held;

  logic push_ok, push_drop, pop, start, byte_done;

  // Fullness uses the pre-pop count, so a push into a full FIFO is dropped
  // even when a pop happens in the same cycle.
  assign push_ok   = rec_valid && (count < CW'(DEPTH));
  assign push_drop = rec_valid && !push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx_send    = 1'b0;
    tx_byte    = 8'h00;
    busy       = 1'b1;
    pop        = 1'b0;
    start      = 1'b0;
    byte_done  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (pending || frame_done) begin
          start      = 1'b1;
          next_state = (count != '0) ? S_LOAD : S_NONE;
        end
      end
      S_LOAD: begin
        pop        = 1'b1;
        next_state = S_WAIT_CTS;
      end
      S_WAIT_CTS: begin
        if (cts) next_state = S_XMIT;
      end
      S_XMIT: begin
        tx_send = 1'b1;
        tx_byte = shreg[7:0];
        if (tx_done) begin
          byte_done = 1'b1;
          if (byte_idx != BW'(REC_BYTES - 1)) next_state = S_WAIT_CTS;
          else if (burst_left != '0)          next_state = S_LOAD;
          else                                next_state = S_IDLE;
        end
      end
      S_NONE: begin
        tx_byte = NONE_BYTE;
        tx_send = none_held;
        if (none_held && tx_done) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Record storage is not reset; emptiness is tracked by pointers and count.
  always_ff @(posedge clock) begin
    if (push_ok) mem[tail] <= rec_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push_ok) tail <= ptr_inc(tail);
      if (pop)     head <= ptr_inc(head);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending    <= 1'b0;
      burst_left <= '0;
      shreg      <= '0;
      byte_idx   <= '0;
      none_held  <= 1'b0;
    end else begin
      // A strobe arriving in the same cycle IDLE starts a burst is consumed
      // by that burst rather than leaving an extra pending frame behind.
      if (start)           pending <= 1'b0;
      else if (frame_done) pending <= 1'b1;

      if (start)    burst_left <= count;
      else if (pop) burst_left <= burst_left - CW'(1);

      if (pop) begin
        shreg    <= mem[head];
        byte_idx <= '0;
      end else if (byte_done) begin
        shreg    <= shreg >> 8;
        byte_idx <= byte_idx + BW'(1);
      end

      // Once cts has been seen in NONE the request stays up until tx_done.
      none_held <= (next_state == S_NONE) && (none_held || (state == S_NONE && cts));
    end
  end

endmodule

// File: tb/tb_face_result_streamer.sv
module tb_face_result_streamer;
  localparam int DEPTH = 4;
  localparam int RB    = 16;
  localparam int RW    = RB * 8;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [RW-1:0] rec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rec_valid = 1'b0;
  rec_t          rec_data = '0;
  logic          frame_done = 1'b0;
  logic          cts = 1'b1;
  logic          tx_done = 1'b0;
  logic          tx_send;
  logic [7:0]    tx_byte;
  logic [CW-1:0] count;
  logic          busy;
  logic          overflow;
  logic [15:0]   drop_count;

  face_result_streamer #(.DEPTH(DEPTH), .REC_BYTES(RB), .NONE_BYTE(8'h00)) dut (
    .clock(clock), .reset(reset), .rec_valid(rec_valid), .rec_data(rec_data),
    .frame_done(frame_done), .cts(cts), .tx_done(tx_done), .tx_send(tx_send),
    .tx_byte(tx_byte), .count(count), .busy(busy), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of stored records plus drop bookkeeping.
  rec_t        model_q[$];
  int          model_drops = 0;
  bit          model_ovf = 0;
  logic [7:0]  got[$];
  logic [7:0]  exp_b[$];

  function automatic rec_t rand_rec();
    rec_t r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void expect_recs(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = model_q[i];
      for (int k = 0; k < RB; k++) exp_b.push_back(r[k*8 +: 8]);
    end
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic push_rec(input rec_t r);
    rec_valid = 1'b1;
    rec_data  = r;
    if (model_q.size() < DEPTH) model_q.push_back(r);
    else begin model_drops++; model_ovf = 1; end
    @(negedge clock);
    rec_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_done = 1'b1;
    @(negedge clock);
    frame_done = 1'b0;
  endtask

  task automatic rx_byte(input int gap, output logic [7:0] b, output bit ok, output bit stable);
    ok = 0; stable = 1; b = 8'h00;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (tx_send === 1'b1) ok = 1;
      else @(negedge clock);
    end
    if (ok) begin
      b = tx_byte;
      repeat (gap) begin
        @(negedge clock);
        if (tx_send !== 1'b1 || tx_byte !== b) stable = 0;
      end
      tx_done = 1'b1;
      @(negedge clock);
      tx_done = 1'b0;
    end
  endtask

  task automatic rx_bytes(input int n, input int gap, output int errs);
    logic [7:0] b; bit ok, st;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      rx_byte((gap < 0) ? $urandom_range(0, 4) : gap, b, ok, st);
      got.push_back(b);
      if (!ok || !st) errs++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({tx_send, tx_byte, count, busy, overflow, drop_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got send=%0b byte=%h count=%0d busy=%0b ovf=%0b drops=%0d want all 0",
               tx_send, tx_byte, count, busy, overflow, drop_count);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_two_records();
    int errs; logic [2:0] seq;
    got.delete(); exp_b.delete();
    push_rec(rand_rec());
    push_rec(rand_rec());
    checks++;
    if (count !== CW'(2)) begin failures++; $display("FAIL two_count got %0d want 2", count); end
    cts = 1'b1;
    pulse_frame();
    seq[2] = tx_send; @(negedge clock);
    seq[1] = tx_send; @(negedge clock);
    seq[0] = tx_send;
    checks++;
    if (seq !== 3'b001) begin failures++; $display("FAIL two_latency got %b want 001", seq); end
    expect_recs(2);
    rx_bytes(2 * RB, 4, errs);
    checks++;
    if (errs !== 0) begin failures++; $display("FAIL two_handshake got %0d errors want 0", errs); end
    for (int k = 0; k < exp_b.size(); k++) begin
      checks++;
      if (got[k] !== exp_b[k]) begin failures++; $display("FAIL two_byte%0d got %h want %h", k, got[k], exp_b[k]); end
    end
    repeat (2) void'(model_q.pop_front());
    checks++;
    if (count !== CW'(model_q.size()) || busy !== 1'b0) begin
      failures++; $display("FAIL two_end got count=%0d busy=%0b want %0d/0", count, busy, model_q.size());
    end
  endtask

  task automatic test_empty_frame();
    logic [7:0] b; bit ok, st;
    pulse_frame();
    rx_byte($urandom_range(0, 4), b, ok, st);
    checks++;
    if (!ok || !st || b !== 8'h00) begin
      failures++; $display("FAIL none_byte got ok=%0b stable=%0b byte=%h want 1/1/00", ok, st, b);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || count !== '0 || tx_send !== 1'b0) begin
      failures++; $display("FAIL none_end got busy=%0b count=%0d send=%0b want 0/0/0", busy, count, tx_send);
    end
    tx_done = 1'b1;
    @(negedge clock);
    tx_done = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || tx_send !== 1'b0) begin
      failures++; $display("FAIL idle_tx_done got busy=%0b send=%0b want 0/0", busy, tx_send);
    end
  endtask

  task automatic test_overflow();
    int errs;
    got.delete(); exp_b.delete();
    for (int i = 0; i < 6; i++) push_rec(rand_rec());
    checks++;
    if (count !== CW'(model_q.size()) || overflow !== model_ovf || drop_count !== 16'(model_drops)) begin
      failures++; $display("FAIL ovf_fill got count=%0d ovf=%0b drops=%0d want %0d/%0b/%0d",
                           count, overflow, drop_count, model_q.size(), model_ovf, model_drops);
    end
    expect_recs(DEPTH);
    pulse_frame();
    // Serialiser is now in the pop cycle; the full FIFO must still drop this push.
    push_rec(rand_rec());
    checks++;
    if (drop_count !== 16'(model_drops) || count !== CW'(DEPTH - 1)) begin
      failures++; $display("FAIL ovf_push_pop got drops=%0d count=%0d want %0d/%0d",
                           drop_count, count, model_drops, DEPTH - 1);
    end
    rx_bytes(DEPTH * RB, -1, errs);
    checks++;
    if (errs !== 0) begin failures++; $display("FAIL ovf_handshake got %0d errors want 0", errs); end
    for (int k = 0; k < exp_b.size(); k++) begin
      checks++;
      if (got[k] !== exp_b[k]) begin failures++; $display("FAIL ovf_byte%0d got %h want %h", k, got[k], exp_b[k]); end
    end
    repeat (DEPTH) void'(model_q.pop_front());
    checks++;
    if (count !== '0 || busy !== 1'b0) begin failures++; $display("FAIL ovf_end got count=%0d busy=%0b want 0/0", count, busy); end
  endtask

  task automatic test_cts_stall();
    int errs, e2, stall_bad; bit seen;
    got.delete(); exp_b.delete();
    push_rec(rand_rec());
    expect_recs(1);
    pulse_frame();
    rx_bytes(2, -1, errs);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (tx_send === 1'b1) seen = 1; else @(negedge clock);
    end
    cts = 1'b0;
    rx_bytes(1, 3, e2);
    errs += e2 + (seen ? 0 : 1);
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_send !== 1'b0) stall_bad++;
      @(negedge clock);
    end
    checks++;
    if (stall_bad !== 0) begin failures++; $display("FAIL cts_stall got %0d cycles with tx_send want 0", stall_bad); end
    cts = 1'b1;
    rx_bytes(RB - 3, -1, e2);
    errs += e2;
    checks++;
    if (errs !== 0) begin failures++; $display("FAIL cts_handshake got %0d errors want 0", errs); end
    for (int k = 0; k < RB; k++) begin
      checks++;
      if (got[k] !== exp_b[k]) begin failures++; $display("FAIL cts_byte%0d got %h want %h", k, got[k], exp_b[k]); end
    end
    void'(model_q.pop_front());
  endtask

  task automatic test_mid_burst();
    int errs, e2; rec_t c;
    got.delete(); exp_b.delete();
    push_rec(rand_rec());
    expect_recs(1);
    pulse_frame();
    rx_bytes(5, -1, errs);
    c = rand_rec();
    push_rec(c);
    checks++;
    if (count !== CW'(1)) begin failures++; $display("FAIL mid_count got %0d want 1", count); end
    pulse_frame();
    rx_bytes(RB - 5, -1, e2);
    errs += e2;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_burst_end got busy=%0b want 0", busy); end
    void'(model_q.pop_front());
    expect_recs(1);
    rx_bytes(RB, -1, e2);
    errs += e2;
    checks++;
    if (errs !== 0) begin failures++; $display("FAIL mid_handshake got %0d errors want 0", errs); end
    for (int k = 0; k < 2 * RB; k++) begin
      checks++;
      if (got[k] !== exp_b[k]) begin failures++; $display("FAIL mid_byte%0d got %h want %h", k, got[k], exp_b[k]); end
    end
    void'(model_q.pop_front());
    checks++;
    if (count !== '0 || busy !== 1'b0) begin failures++; $display("FAIL mid_end got count=%0d busy=%0b want 0/0", count, busy); end
  endtask

  task automatic test_wrap();
    int n, errs, bad;
    for (int it = 0; it < 10; it++) begin
      got.delete(); exp_b.delete();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) push_rec(rand_rec());
      expect_recs(n);
      pulse_frame();
      rx_bytes(n * RB, -1, errs);
      bad = 0;
      for (int k = 0; k < exp_b.size(); k++) if (got[k] !== exp_b[k]) bad++;
      repeat (n) void'(model_q.pop_front());
      checks++;
      if (errs !== 0 || bad !== 0 || count !== '0) begin
        failures++; $display("FAIL wrap_iter%0d got errs=%0d bad_bytes=%0d count=%0d want 0/0/0", it, errs, bad, count);
      end
    end
  endtask

  task automatic test_reset_mid_xmit();
    int errs; bit seen;
    push_rec(rand_rec());
    push_rec(rand_rec());
    pulse_frame();
    rx_bytes(3, -1, errs);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (tx_send === 1'b1) seen = 1; else @(negedge clock);
    end
    checks++;
    if (!seen || errs !== 0) begin failures++; $display("FAIL rst_setup got seen=%0b errs=%0d want 1/0", seen, errs); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx_send !== 1'b0 || count !== '0 || busy !== 1'b0 || overflow !== 1'b0 || drop_count !== '0) begin
      failures++; $display("FAIL rst_async got send=%0b count=%0d busy=%0b ovf=%0b drops=%0d want all 0",
                           tx_send, count, busy, overflow, drop_count);
    end
    model_q.delete(); model_drops = 0; model_ovf = 0;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (tx_send !== 1'b0 || busy !== 1'b0 || count !== '0) begin
      failures++; $display("FAIL rst_after got send=%0b busy=%0b count=%0d want 0/0/0", tx_send, busy, count);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_two_records();
    test_empty_frame();
    test_overflow();
    test_cts_stall();
    test_mid_burst();
    test_wrap();
    test_reset_mid_xmit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
